// File: rtl/simon_key_schedule_pkg.sv
// ============================================================================
// Module      : simon_pkg (package)
// Description : Shared Simon constants and helpers: z-sequences, round count
//               and z-sequence lookups, legal (n,m) check, round constant C.
// Revision    : 1.0 - parametrised successor to the Simon32/64-only generator
// ============================================================================
`default_nettype none

package simon_pkg;

  localparam int c_Z_LEN = 62;

  // Published sequences are written first-symbol-leftmost; flip so bit j holds symbol j.
  function automatic logic [61:0] rev62(input logic [61:0] s);
    logic [61:0] r;
    for (int j = 0; j < 62; j++) r[j] = s[61-j];
    return r;
  endfunction

  localparam logic [61:0] Z_SEQ [0:4] = '{
    rev62(62'b11111010001001010110000111001101111101000100101011000011100110),
    rev62(62'b10001110111110010011000010110101000111011111001001100001011010),
    rev62(62'b10101111011100000011010010011000101000010001111110010110110011),
    rev62(62'b11011011101011000110010111100000010010001010011100110100001111),
    rev62(62'b11010001111001101011011000100000010111000011001010010011101111)
  };

  function automatic bit legal_pair(input int n, input int m);
    case (n)
      16:      return (m == 4);
      24, 32:  return (m == 3) || (m == 4);
      48:      return (m == 2) || (m == 3);
      64:      return (m >= 2) && (m <= 4);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int rounds(input int n, input int m);
    case (n)
      16:      return 32;
      24:      return 36;
      32:      return (m == 3) ? 42 : 44;
      48:      return (m == 2) ? 52 : 54;
      64:      return (m == 2) ? 68 : ((m == 3) ? 69 : 72);
      default: return 0;
    endcase
  endfunction

  function automatic int zsel(input int n, input int m);
    case (n)
      16:      return 0;
      24:      return (m == 3) ? 0 : 1;
      32:      return (m == 3) ? 2 : 3;
      48:      return (m == 2) ? 2 : 3;
      64:      return (m == 2) ? 2 : ((m == 3) ? 3 : 4);
      default: return 0;
    endcase
  endfunction

  // Round constant C = 2^n - 4 in the low n bits of a 64-bit word.
  function automatic logic [63:0] const_c(input int n);
    logic [63:0] mask;
    mask = (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    return mask & ~64'd3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/simon_key_schedule_step.sv
// ============================================================================
// Module      : simon_ks_step
// Description : Combinational Simon key recurrence, one new key word from the
//               oldest window word, the second word, the newest word and z.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_ks_step
  import simon_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4
) (
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] wlast,
  input  logic              zbit,
  output logic [WORD_W-1:0] new_word
);

  localparam logic [WORD_W-1:0] c_C = WORD_W'(const_c(WORD_W));

  logic [WORD_W-1:0] w_ror3;
  logic [WORD_W-1:0] w_mix;
  logic [WORD_W-1:0] w_tmp;

  assign w_ror3 = {wlast[2:0], wlast[WORD_W-1:3]};

  // Only four-word keys fold in the second window word.
  if (KEY_WORDS == 4) begin : g_m4
    assign w_mix = w_ror3 ^ w1;
  end else begin : g_m23
    logic w_unused_w1;
    assign w_unused_w1 = ^w1;
    assign w_mix       = w_ror3;
  end

  assign w_tmp    = w_mix ^ {w_mix[0], w_mix[WORD_W-1:1]};
  assign new_word = c_C ^ w0 ^ w_tmp ^ {{(WORD_W-1){1'b0}}, zbit};

endmodule

`default_nettype wire

// File: rtl/simon_key_schedule.sv
// ============================================================================
// Module      : simon_key_schedule
// Description : Streams Simon round keys k[0]..k[T-1] from a master key over a
//               valid/ready interface, one key per cycle with backpressure.
//               Optional SIMON_KS_RESTART_EN adds a restart input that replays
//               the schedule from a shadow copy of the master key.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simon_key_schedule
  import simon_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_valid,
  output logic                        key_ready,
  input  logic [WORD_W*KEY_WORDS-1:0] key_in,
  output logic                        rk_valid,
  input  logic                        rk_ready,
  output logic [WORD_W-1:0]           rk_data,
  output logic [7:0]                  rk_index,
  output logic                        rk_last,
  output logic                        busy
`ifdef SIMON_KS_RESTART_EN
  ,
  input  logic                        restart
`endif
);

  localparam int          ROUNDS     = rounds(WORD_W, KEY_WORDS);
  localparam logic [7:0]  c_LAST_IDX = 8'(ROUNDS - 1);
  localparam logic [61:0] c_Z        = Z_SEQ[zsel(WORD_W, KEY_WORDS)];
  localparam logic [5:0]  c_ZC_MAX   = 6'(c_Z_LEN - 1);

  localparam logic [0:0]  c_S_IDLE   = 1'b0;
  localparam logic [0:0]  c_S_RUN    = 1'b1;

  if (!legal_pair(WORD_W, KEY_WORDS)) begin : g_illegal_pair
    $error("simon_key_schedule: unsupported (WORD_W, KEY_WORDS) pair");
  end

  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic [WORD_W-1:0] r_win [KEY_WORDS];
  logic [7:0]        r_idx;
  logic [5:0]        r_zc;
  logic              w_run;
  logic              w_load;
  logic              w_accept;
  logic              w_at_last;
  logic              w_restart;
  logic              w_advance;
  logic              w_zbit;
  logic [WORD_W-1:0] w_new;

  assign w_run     = (r_state == c_S_RUN);
  assign w_load    = !w_run && key_valid;
  assign w_accept  = w_run && rk_ready;
  assign w_at_last = (r_idx == c_LAST_IDX);
  assign w_advance = w_accept && !w_at_last && !w_restart;
  assign w_zbit    = c_Z[r_zc];

`ifdef SIMON_KS_RESTART_EN
  logic [WORD_W*KEY_WORDS-1:0] r_shadow;

  assign w_restart = w_run && restart;

  // Keep the master key for the whole schedule so it can be replayed.
  always_ff @(posedge clk) begin
    if (rst)         r_shadow <= '0;
    else if (w_load) r_shadow <= key_in;
  end
`else
  assign w_restart = 1'b0;
`endif

  simon_ks_step #(
    .WORD_W    (WORD_W),
    .KEY_WORDS (KEY_WORDS)
  ) u_step (
    .w0       (r_win[0]),
    .w1       (r_win[1]),
    .wlast    (r_win[KEY_WORDS-1]),
    .zbit     (w_zbit),
    .new_word (w_new)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_S_IDLE;
    else     r_state <= w_state_next;
  end

  // Leave RUN only when the final key is taken and no replay is requested.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_IDLE: if (key_valid) w_state_next = c_S_RUN;
      c_S_RUN:  if (w_accept && w_at_last && !w_restart) w_state_next = c_S_IDLE;
      default:  w_state_next = c_S_IDLE;
    endcase
  end

  // Handshake and status outputs depend on state only, never on rk_ready.
  always_comb begin
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    busy      = 1'b0;
    rk_last   = 1'b0;
    case (r_state)
      c_S_IDLE: key_ready = 1'b1;
      c_S_RUN: begin
        rk_valid = 1'b1;
        busy     = 1'b1;
        rk_last  = w_at_last;
      end
      default: key_ready = 1'b0;
    endcase
  end

  // Sliding window of k[i..i+m-1] with round and z counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < KEY_WORDS; j++) r_win[j] <= '0;
      r_idx <= '0;
      r_zc  <= '0;
    end else if (w_load) begin
      for (int j = 0; j < KEY_WORDS; j++) r_win[j] <= key_in[j*WORD_W +: WORD_W];
      r_idx <= '0;
      r_zc  <= '0;
`ifdef SIMON_KS_RESTART_EN
    end else if (w_restart) begin
      for (int j = 0; j < KEY_WORDS; j++) r_win[j] <= r_shadow[j*WORD_W +: WORD_W];
      r_idx <= '0;
      r_zc  <= '0;
`endif
    end else if (w_advance) begin
      for (int j = 0; j < KEY_WORDS-1; j++) r_win[j] <= r_win[j+1];
      r_win[KEY_WORDS-1] <= w_new;
      r_idx <= r_idx + 8'd1;
      r_zc  <= (r_zc == c_ZC_MAX) ? 6'd0 : r_zc + 6'd1;
    end
  end

  assign rk_data  = r_win[0];
  assign rk_index = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_simon_key_schedule.sv
// ============================================================================
// Module      : tb_simon_key_schedule
// Description : Self-checking bench: Simon32/64 instance driven by directed
//               steps with a scoreboard, plus one instance per other (n,m)
//               pair compared against an independent key-schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simon_key_schedule;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  i;
    logic        l;
  } exp_t;

  localparam int NS [9] = '{24, 24, 32, 32, 48, 48, 64, 64, 64};
  localparam int MS [9] = '{3, 4, 3, 4, 2, 3, 2, 3, 4};
  localparam int TS [9] = '{36, 36, 42, 44, 52, 54, 68, 69, 72};
  localparam int ZS [9] = '{0, 1, 2, 3, 2, 3, 2, 3, 4};

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
  logic        rk_valid;
  logic        rk_ready;
  logic [15:0] rk_data;
  logic [7:0]  rk_index;
  logic        rk_last;
  logic        busy;
  logic        restart;

  logic [255:0] x_key    [9];
  logic         x_kvalid;
  logic         x_kready [9];
  logic         x_valid  [9];
  logic [63:0]  x_data   [9];
  logic [7:0]   x_idx    [9];
  logic         x_last   [9];
  logic         x_busy   [9];

  logic [61:0] zl  [5];
  logic [63:0] mk  [10][80];
  logic [15:0] vec [5];
  exp_t        sb[$];
  int          checks;
  int          failures;

  simon_key_schedule #(.WORD_W(16), .KEY_WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_index  (rk_index),
    .rk_last   (rk_last),
    .busy      (busy)
`ifdef SIMON_KS_RESTART_EN
    ,
    .restart   (restart)
`endif
  );

  for (genvar g = 0; g < 9; g++) begin : g_pair
    logic [NS[g]-1:0] d;
    simon_key_schedule #(.WORD_W(NS[g]), .KEY_WORDS(MS[g])) u_pair (
      .clk       (clk),
      .rst       (rst),
      .key_valid (x_kvalid),
      .key_ready (x_kready[g]),
      .key_in    (x_key[g][NS[g]*MS[g]-1:0]),
      .rk_valid  (x_valid[g]),
      .rk_ready  (1'b1),
      .rk_data   (d),
      .rk_index  (x_idx[g]),
      .rk_last   (x_last[g]),
      .busy      (x_busy[g])
`ifdef SIMON_KS_RESTART_EN
      ,
      .restart   (1'b0)
`endif
    );
    assign x_data[g] = 64'(d);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n,
                                      input logic [63:0] mask);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  // Reference key expansion into mk[s][0..t_total-1].
  task automatic build(input int s, input int n, input int m, input int t_total,
                       input int zs, input logic [255:0] key);
    logic [63:0] mask;
    logic [63:0] cst;
    logic [63:0] tmp;
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    cst  = mask & ~64'd3;
    for (int j = 0; j < m; j++) mk[s][j] = 64'(key >> (j * n)) & mask;
    for (int t = m; t < t_total; t++) begin
      tmp = ror(mk[s][t-1], 3, n, mask);
      if (m == 4) tmp = tmp ^ mk[s][t-3];
      tmp = tmp ^ ror(tmp, 1, n, mask);
      mk[s][t] = cst ^ mk[s][t-m] ^ tmp ^ 64'(zl[zs][61 - ((t - m) % 62)]);
    end
  endtask

  task automatic push_main(input logic [63:0] k);
    build(0, 16, 4, 32, 0, {192'd0, k});
    for (int t = 0; t < 32; t++) sb.push_back('{d: mk[0][t][15:0], i: 8'(t), l: (t == 31)});
  endtask

  task automatic load_main(input logic [63:0] k);
    chk("key_ready_idle", key_ready, 1);
    key_in    = k;
    key_valid = 1'b1;
    push_main(k);
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("first_key_latency", {rk_valid, rk_index}, {1'b1, 8'd0});
  endtask

  task automatic wait_done(input bit rand_ready, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      if (!rk_valid) done = 1'b1;
      else begin
        chk("key_ready_in_run", {key_ready, busy}, 2'b01);
        rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
      end
    end
    rk_ready = 1'b1;
    chk("schedule_done", done, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic wait_index(input int n);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (rk_valid && rk_index == 8'(n)) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("reach_index", hit, 1);
  endtask

  // Scoreboard monitor: every shown round key must equal the queue head; pop on transfer.
  always @(negedge clk) begin
    if (!rst && rk_valid) begin
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        chk("rk_data", rk_data, sb[0].d);
        chk("rk_index", rk_index, sb[0].i);
        chk("rk_last", rk_last, sb[0].l);
        if (rk_ready && !restart) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [63:0] ka;
    logic [63:0] kb;
    bit          accepted;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_ready  = 1'b1;
    restart   = 1'b0;
    x_kvalid  = 1'b0;
    for (int g = 0; g < 9; g++) x_key[g] = '0;
    zl[0] = 62'b11111010001001010110000111001101111101000100101011000011100110;
    zl[1] = 62'b10001110111110010011000010110101000111011111001001100001011010;
    zl[2] = 62'b10101111011100000011010010011000101000010001111110010110110011;
    zl[3] = 62'b11011011101011000110010111100000010010001010011100110100001111;
    zl[4] = 62'b11010001111001101011011000100000010111000011001010010011101111;
    vec = '{16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {key_ready, rk_valid, rk_data, rk_index, rk_last, busy},
        {1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0});
    rst = 1'b0;
    @(posedge clk); #1;

    // Simon32/64 published key, no stalls.
    load_main(64'h1918_1110_0908_0100);
    for (int c = 0; c < 5; c++) begin
      chk("simon32_64_vector", rk_data, vec[c]);
      @(posedge clk); #1;
    end
    wait_done(1'b0, 100);
    chk("idle_after_last", {rk_valid, key_ready, rk_last}, 3'b010);

    // Random backpressure.
    load_main({$urandom, $urandom});
    wait_done(1'b1, 400);

    // Key offered mid-schedule is ignored until the last key is taken.
    ka = {$urandom, $urandom};
    kb = {$urandom, $urandom};
    load_main(ka);
    repeat (3) begin @(posedge clk); #1; end
    key_in    = kb;
    key_valid = 1'b1;
    accepted  = 1'b0;
    for (int c = 0; c < 100 && !accepted; c++) begin
      if (key_ready) begin
        chk("prev_drained_before_accept", sb.size(), 0);
        push_main(kb);
        accepted = 1'b1;
      end else begin
        chk("key_ignored_in_run", {key_ready, rk_valid}, 2'b01);
        @(posedge clk); #1;
      end
    end
    chk("second_key_accepted", accepted, 1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("second_key_first", {rk_valid, rk_index}, {1'b1, 8'd0});
    wait_done(1'b0, 100);

    // Reset mid-schedule at index 10, then a fresh key.
    load_main({$urandom, $urandom});
    wait_index(10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", {rk_valid, rk_data, key_ready, busy, rk_last},
        {1'b0, 16'h0, 1'b1, 1'b0, 1'b0});
    sb.delete();
    rst = 1'b0;
    load_main({$urandom, $urandom});
    wait_done(1'b0, 100);

`ifdef SIMON_KS_RESTART_EN
    // Restart at index 20 with a simultaneous acceptance replays from k[0].
    ka = {$urandom, $urandom};
    load_main(ka);
    wait_index(20);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    sb.delete();
    push_main(ka);
    chk("restart_k0", {rk_valid, rk_index, rk_data}, {1'b1, 8'd0, mk[0][0][15:0]});
    wait_done(1'b0, 100);
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    chk("restart_idle_ignored", {rk_valid, key_ready}, 2'b01);
`endif

    // Every other (n,m) pair, stall-free, against the reference model.
    for (int g = 0; g < 9; g++) begin
      x_key[g] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      build(g + 1, NS[g], MS[g], TS[g], ZS[g], x_key[g]);
      chk("pair_key_ready", x_kready[g], 1);
    end
    x_kvalid = 1'b1;
    @(posedge clk); #1;
    x_kvalid = 1'b0;
    for (int c = 0; c <= 72; c++) begin
      for (int g = 0; g < 9; g++) begin
        if (c < TS[g])
          chk("pair_round_key", {x_valid[g], x_idx[g], x_last[g], x_data[g]},
              {1'b1, 8'(c), (c == TS[g] - 1), mk[g+1][c]});
        else if (c == TS[g])
          chk("pair_end", {x_valid[g], x_busy[g], x_kready[g]}, 3'b001);
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/simon_key_schedule.md
Name: simon_key_schedule

Overview:
- Parametrised Simon round-key generator covering all ten Simon block/key variants; successor to the fixed 16-bit, Simon32/64-only subkey generator.
- Accepts a master key through a valid/ready handshake and streams round keys k[0]..k[T-1], one per cycle, with backpressure.
- Sits between the key loader and the round datapath. The datapath consumes one round key per round.

Parameters:
- WORD_W, 16: word size n in bits; legal values 16, 24, 32, 48, 64.
- KEY_WORDS, 4: key words m; legal values 2, 3, 4, restricted to valid Simon (n,m) pairs.
- ROUNDS, derived: round count T from the package lookup (e.g. 32 for 16/4, 44 for 32/4, 72 for 64/4). Not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- key_valid  in  1  master key offered
- key_ready  out  1  block can accept key
- key_in  in  WORD_W*KEY_WORDS  master key; word j = k[j] at bits [j*WORD_W +: WORD_W]
- rk_valid  out  1  round key valid
- rk_ready  in  1  consumer accepts round key
- rk_data  out  WORD_W  round key k[i]
- rk_index  out  8  round index i
- rk_last  out  1  high with k[T-1]
- busy  out  1  schedule in progress
- restart  in  1  replay schedule from k[0]; present only with SIMON_KS_RESTART_EN

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: key_ready=1, rk_valid=0, rk_data=0, rk_index=0, rk_last=0, busy=0. All window registers, the round counter and the z counter clear to 0.
- State machine:
  - IDLE: key_ready=1. A key_valid&key_ready cycle loads window w[0..m-1] <= k[0..m-1], sets i=0 and zc=0, and moves to RUN.
  - RUN: rk_valid=1, rk_data=w[0], rk_index=i, busy=1, key_ready=0. key_valid is ignored.
  - On rk_valid&rk_ready with i<T-1: shift w[j] <= w[j+1], set w[m-1] <= new, i++, zc = (zc==61) ? 0 : zc+1.
  - On acceptance with i==T-1: go to IDLE, drop rk_valid, set rk_last=0.
- Output latency: k[0] appears on rk_data the cycle after the key handshake. After that, sustained throughput is one key per cycle while rk_ready=1.
- Backpressure: while rk_ready=0, rk_data, rk_index and rk_last hold stable. There is no combinational path from rk_ready to rk_valid.
- Key recurrence (window holds k[i..i+m-1]), with all arithmetic mod 2^n:
  - tmp = ROR3(w[m-1]).
  - For m=4 only: tmp ^= w[1].
  - tmp ^= ROR1(tmp).
  - new = C ^ w[0] ^ tmp ^ z_bit. C = 2^n-4 (all ones except the low two bits). z_bit = Z[zsel][zc] occupies bit 0 only.
- The first m outputs are the master key words unchanged. zc indexes k[i+m], using i mod 62.
- rk_last = (i==T-1) during RUN.
- An rst during RUN aborts immediately. After reset the block is back in IDLE with no output.

Optional Feature:
- SIMON_KS_RESTART_EN defined:
  - The master key is held in a shadow register for the whole schedule.
  - In RUN, restart=1 reloads the window from the shadow and sets i=0, zc=0 the next cycle. This lets a second block under the same key be processed without reloading the key.
  - restart beats a simultaneous rk_ready acceptance, and that acceptance is discarded.
  - restart in IDLE is ignored.
- SIMON_KS_RESTART_EN undefined: no restart port, no shadow register.

Decomposition:
- Package simon_pkg holds:
  - Z_SEQ[0:4]: 62-bit z0..z4 constants. Bit j is the j-th symbol of the published sequence.
  - Function rounds(n,m) and function zsel(n,m).
  - Legal-pair check.
  - C constant function.
- One sub-module, simon_ks_step: combinational recurrence (w0, w1, wlast, zbit -> new), parametrised by WORD_W and KEY_WORDS. It is reusable by the cipher's inline key expansion.

Test Plan:
- Simon32/64 (16,4): key words 0x0100, 0x0908, 0x1110, 0x1918 with rk_ready=1 -> outputs 0x0100, 0x0908, 0x1110, 0x1918, 0x71C3. Exactly 32 keys, rk_last on index 31, and rk_valid returns low the next cycle.
- Backpressure: random rk_ready gaps -> key sequence identical to the stall-free run, with outputs held during stalls.
- All ten (n,m) pairs: generated keys match a golden model with published vectors. Count equals T, and the z counter wraps past 61 for T>62 (128/256, T=72).
- Key offered during RUN: key_valid=1 mid-schedule -> ignored, key_ready=0. The next key is accepted only after k[T-1] is consumed.
- rst asserted at index 10 -> the next cycle rk_valid=0, rk_data=0, key_ready=1. A fresh key afterwards restarts at k[0].
- With SIMON_KS_RESTART_EN: restart at index 20 together with rk_ready=1 -> the next output is k[0] with index 0, and the full sequence repeats.
